// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command path (SPI mode).
package sd_pkg;

  typedef enum logic [2:0] {
    IDLE, PRE, FRAME, POLL, EXTRA, POST, DONE
  } sd_state_e;

  localparam logic [7:0] SD_FILL_BYTE     = 8'hFF;
  localparam logic [6:0] SD_CRC7_POLY     = 7'h09;
  localparam int         SD_FRAME_BYTES   = 6;
  localparam int         SD_TRAILER_BYTES = 4;

  // CRC7 over the 40 leading frame bits, MSB first, register starting at zero.
  function automatic logic [6:0] sd_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ SD_CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte shifter: one byte per start, MSB first, SCLK half-period CLK_DIV clocks.
module sd_spi_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       byte_done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    sh;
  logic          half_end;

  assign half_end = active && (div_cnt == DW'(CLK_DIV - 1));
  // Asserted in the cycle before the 8th falling edge, so a new start can
  // chain straight on and the byte stream has no gap.
  assign byte_done = half_end && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= '1;
      rx      <= 8'hFF;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else if (start && (!active || byte_done)) begin
      active  <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      sh      <= tx[6:0];
      sclk    <= 1'b0;
      mosi    <= tx[7];
    end else if (byte_done) begin
      active  <= 1'b0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
    end else if (half_end) begin
      div_cnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
        rx   <= {rx[6:0], miso};
      end else begin
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        mosi    <= sh[6];
        sh      <= {sh[5:0], 1'b1};
      end
    end else if (active) begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_cmd_frame.sv
// SD SPI command engine: frame build, R1 poll, optional 32-bit trailer.
// Define SD_CMD_CRC_EN for a real CRC7; otherwise fixed CMD0/CMD8 CRC bytes.
module sd_cmd_frame
  import sd_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic        startprep,
  input  logic        start40prep,
  input  logic        startnocrc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic [31:0] r32,
  output logic        timeout,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam logic [7:0] FRAME_LAST = 8'(SD_FRAME_BYTES - 1);
  localparam logic [7:0] POLL_LAST  = 8'(NCR_MAX - 1);
  localparam logic [7:0] TRL_LAST   = 8'(SD_TRAILER_BYTES - 1);

  sd_state_e   state, state_nxt;
  logic [7:0]  idx, idx_nxt;
  logic [47:0] frame_q;
  logic        ext_q;
  logic        accept;
  logic [7:0]  crc_byte;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        byte_done;

  assign accept = (state == IDLE) && (startprep || start40prep || startnocrc);
  assign busy   = (state != IDLE) && (state != DONE);
  assign done   = (state == DONE);

`ifdef SD_CMD_CRC_EN
  always_comb
    crc_byte = (startnocrc && !startprep && !start40prep) ? SD_FILL_BYTE
                                                           : {sd_crc7({2'b01, cmd, arg}), 1'b1};
`else
  // Only CMD0 and CMD8 are CRC-checked by a card still in SPI mode.
  always_comb begin
    case (cmd)
      6'd0:    crc_byte = 8'h95;
      6'd8:    crc_byte = 8'h87;
      default: crc_byte = SD_FILL_BYTE;
    endcase
  end
`endif

  sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_byte (
    .clk       (clk),
    .rst       (rst),
    .start     (spi_start),
    .tx        (spi_tx),
    .rx        (spi_rx),
    .byte_done (byte_done),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    spi_start = 1'b0;
    spi_tx    = SD_FILL_BYTE;
    case (state)
      IDLE: if (accept) begin
        spi_start = 1'b1;
        state_nxt = PRE;
      end
      PRE: if (byte_done) begin
        spi_start = 1'b1;
        spi_tx    = frame_q[47:40];
        idx_nxt   = '0;
        state_nxt = FRAME;
      end
      FRAME: if (byte_done) begin
        spi_start = 1'b1;
        if (idx == FRAME_LAST) begin
          idx_nxt   = '0;
          state_nxt = POLL;
        end else begin
          spi_tx  = frame_q[39:32];
          idx_nxt = idx + 8'd1;
        end
      end
      POLL: if (byte_done) begin
        spi_start = 1'b1;
        if (!spi_rx[7]) begin
          idx_nxt   = '0;
          state_nxt = ext_q ? EXTRA : POST;
        end else if (idx == POLL_LAST) begin
          idx_nxt   = '0;
          state_nxt = POST;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      EXTRA: if (byte_done) begin
        spi_start = 1'b1;
        if (idx == TRL_LAST) begin
          idx_nxt   = '0;
          state_nxt = POST;
        end else begin
          idx_nxt = idx + 8'd1;
        end
      end
      POST:    if (byte_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      frame_q <= '1;
      ext_q   <= 1'b0;
      r1      <= 8'hFF;
      r32     <= '0;
      timeout <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cs_n  <= !(state_nxt inside {PRE, FRAME, POLL, EXTRA});
      if (accept) begin
        frame_q <= {2'b01, cmd, arg, crc_byte};
        ext_q   <= start40prep;
        timeout <= 1'b0;
      end
      // Next frame byte always sits in [39:32] once the current one has gone out.
      if (state == FRAME && byte_done) frame_q <= {frame_q[39:0], SD_FILL_BYTE};
      if (state == POLL && byte_done) begin
        if (!spi_rx[7]) begin
          r1 <= spi_rx;
        end else if (idx == POLL_LAST) begin
          r1      <= 8'hFF;
          timeout <= 1'b1;
        end
      end
      if (state == EXTRA && byte_done) r32 <= {r32[23:0], spi_rx};
    end
  end

endmodule

// File: tb/tb_sd_cmd_frame.sv
// Bench for sd_cmd_frame: SPI card model, byte-level reference model, CLK_DIV=4 and CLK_DIV=1 instances.
module tb_sd_cmd_frame;

  localparam int CLK_DIV = 4;
  localparam int NCR_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        startprep, start40prep, startnocrc;
  logic        busy, done, timeout, sclk, mosi, miso, cs_n;
  logic [7:0]  r1;
  logic [31:0] r32;

  logic        f_start;
  logic        f_busy, f_done, f_timeout, f_sclk, f_mosi, f_cs_n;
  logic [7:0]  f_r1;
  logic [31:0] f_r32;

  always #5 clk = ~clk;

  sd_cmd_frame #(.CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .arg(arg),
    .startprep(startprep), .start40prep(start40prep), .startnocrc(startnocrc),
    .busy(busy), .done(done), .r1(r1), .r32(r32), .timeout(timeout),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  sd_cmd_frame #(.CLK_DIV(1), .NCR_MAX(NCR_MAX)) u_fast (
    .clk(clk), .rst(rst), .cmd(6'd0), .arg(32'd0),
    .startprep(f_start), .start40prep(1'b0), .startnocrc(1'b0),
    .busy(f_busy), .done(f_done), .r1(f_r1), .r32(f_r32), .timeout(f_timeout),
    .sclk(f_sclk), .mosi(f_mosi), .miso(1'b1), .cs_n(f_cs_n)
  );

  // Card model: records every MOSI byte with cs_n, drives MISO from a byte table.
  logic       clr;
  int         bitpos;
  logic [7:0] rx_sh;
  logic       mosi_rise;
  logic [8:0] mon_q[$];
  logic [7:0] miso_stream [0:63];

  always @(posedge sclk or posedge clr) begin
    if (clr) begin
      bitpos <= 0;
      rx_sh  <= '0;
      mon_q.delete();
      miso   <= miso_stream[0][7];
    end else begin
      rx_sh     <= {rx_sh[6:0], mosi};
      mosi_rise <= mosi;
      if (bitpos % 8 == 7) mon_q.push_back({cs_n, rx_sh[6:0], mosi});
      bitpos <= bitpos + 1;
      miso   <= miso_stream[((bitpos + 1) / 8) % 64][7 - ((bitpos + 1) % 8)];
    end
  end

  int busy_cnt, done_cnt;
  int glitch = 0, f_glitch = 0, f_rise = 0, f_busy_cnt = 0, f_done_cnt = 0;
  logic f_mosi_rise;

  always @(negedge clk or posedge clr) begin
    if (clr) begin
      busy_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  always @(posedge f_sclk) begin
    f_rise      <= f_rise + 1;
    f_mosi_rise <= f_mosi;
  end

  always @(negedge clk) begin
    if (sclk && mosi !== mosi_rise) glitch <= glitch + 1;
    if (f_sclk && f_mosi !== f_mosi_rise) f_glitch <= f_glitch + 1;
    if (f_busy) f_busy_cnt <= f_busy_cnt + 1;
    if (f_done) f_done_cnt <= f_done_cnt + 1;
  end

  int checks = 0, errors = 0;
  logic [31:0] m_r32;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1, by long division.
  function automatic logic [6:0] m_crc7(input logic [5:0] c, input logic [31:0] a);
    logic [46:0] v;
    v = {2'b01, c, a, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    return v[6:0];
  endfunction

  task automatic load_card(input int k, input logic [7:0] r1v, input logic [31:0] trl);
    for (int i = 0; i < 64; i++) miso_stream[i] = 8'hFF;
    miso_stream[7 + k] = r1v;
    for (int j = 0; j < 4; j++) miso_stream[8 + k + j] = trl[31 - 8*j -: 8];
    clr = 1'b1;
    #1 clr = 1'b0;
  endtask

  // mode: 0 startprep, 1 start40prep, 2 startnocrc, 3 startprep+startnocrc together.
  // k: number of 0xFF bytes the card sends before R1.
  task automatic run_txn(input int mode, input logic [5:0] c, input logic [31:0] a, input int k,
                         input logic [7:0] r1v, input logic [31:0] trl, input bit inject,
                         input string tag);
    logic [7:0] frame [0:5];
    logic [7:0] crcb;
    logic [8:0] exp_b;
    bit ext, tmo, got;
    int polls, nbytes;
    ext = (mode == 1);
    tmo = (k >= NCR_MAX);
`ifdef SD_CMD_CRC_EN
    crcb = (mode == 2) ? 8'hFF : {m_crc7(c, a), 1'b1};
`else
    crcb = (c == 6'd0) ? 8'h95 : (c == 6'd8) ? 8'h87 : 8'hFF;
`endif
    frame[0] = {2'b01, c};
    frame[1] = a[31:24];
    frame[2] = a[23:16];
    frame[3] = a[15:8];
    frame[4] = a[7:0];
    frame[5] = crcb;
    polls  = tmo ? NCR_MAX : k + 1;
    nbytes = 1 + 6 + polls + ((ext && !tmo) ? 4 : 0) + 1;

    @(negedge clk);
    load_card(k, r1v, trl);
    cmd = c;
    arg = a;
    startprep   = (mode == 0 || mode == 3);
    start40prep = (mode == 1);
    startnocrc  = (mode == 2 || mode == 3);
    @(negedge clk);
    startprep = 1'b0; start40prep = 1'b0; startnocrc = 1'b0;
    cmd = 6'($urandom);
    arg = $urandom;
    if (inject) begin
      repeat (40) @(negedge clk);
      startprep = 1'b1; start40prep = 1'b1;
      @(negedge clk);
      startprep = 1'b0; start40prep = 1'b0;
    end
    got = 1'b0;
    for (int w = 0; w < 4000 && !got; w++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    repeat (4) @(negedge clk);
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(nbytes * 16 * CLK_DIV));
    check({tag, " byte_count"}, 64'(mon_q.size()), 64'(nbytes));
    for (int n = 0; n < nbytes; n++) begin
      if (n >= 1 && n <= 6) exp_b = {1'b0, frame[n-1]};
      else if (n == nbytes - 1) exp_b = {1'b1, 8'hFF};
      else exp_b = {1'b0, 8'hFF};
      if (n < mon_q.size())
        check($sformatf("%s byte%0d", tag, n), 64'(mon_q[n]), 64'(exp_b));
    end
    if (ext && !tmo) m_r32 = trl;
    check({tag, " r1"}, 64'(r1), 64'(tmo ? 8'hFF : r1v));
    check({tag, " timeout"}, 64'(timeout), 64'(tmo));
    check({tag, " r32"}, 64'(r32), 64'(m_r32));
    check({tag, " cs_n_idle"}, 64'(cs_n), 64'd1);
  endtask

  initial begin
    bit got;
    rst = 1'b1; clr = 1'b0;
    startprep = 1'b0; start40prep = 1'b0; startnocrc = 1'b0; f_start = 1'b0;
    cmd = '0; arg = '0; m_r32 = '0;
    load_card(0, 8'hFF, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst r1", 64'(r1), 64'hFF);
    check("rst r32", 64'(r32), 64'd0);
    check("rst timeout", 64'(timeout), 64'd0);
    check("rst sclk", 64'(sclk), 64'd0);
    check("rst mosi", 64'(mosi), 64'd1);
    check("rst cs_n", 64'(cs_n), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    run_txn(0, 6'd0,  32'h0,         1, 8'h01, 32'h0,          0, "cmd0");
    run_txn(1, 6'd8,  32'h0000_01AA, 0, 8'h01, 32'h0000_01AA,  0, "cmd8");
    run_txn(0, 6'd41, 32'h4000_0000, 9, 8'h00, 32'h1234_5678,  0, "cmd41_tmo");
    run_txn(2, 6'd17, 32'h0000_0200, 2, 8'h00, 32'hDEAD_BEEF,  1, "cmd17_nocrc");
    run_txn(3, 6'd55, 32'hA5A5_0F0F, 0, 8'h01, 32'h0,          0, "prio");

    // Reset in the middle of frame byte 3.
    @(negedge clk);
    load_card(0, 8'h00, 32'h0);
    cmd = 6'd5; arg = 32'h1357_9BDF; startprep = 1'b1;
    @(negedge clk);
    startprep = 1'b0;
    for (int w = 0; w < 2000 && mon_q.size() < 4; w++) @(negedge clk);
    check("midrst reached", 64'(mon_q.size() >= 4), 64'd1);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst cs_n", 64'(cs_n), 64'd1);
    check("midrst sclk", 64'(sclk), 64'd0);
    check("midrst mosi", 64'(mosi), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_r32 = '0;
    repeat (20) @(negedge clk);
    check("midrst no_done", 64'(done_cnt), 64'd0);
    check("midrst r1", 64'(r1), 64'hFF);
    check("midrst r32", 64'(r32), 64'd0);
    run_txn(0, 6'd0, 32'h0, 0, 8'h01, 32'h0, 0, "after_rst");

    for (int t = 0; t < 10; t++)
      run_txn($urandom_range(0, 3), 6'($urandom), $urandom, $urandom_range(0, 9),
              {1'b0, 7'($urandom)}, $urandom, 0, $sformatf("rnd%0d", t));

    check("mosi_stable_div4", 64'(glitch), 64'd0);

    // CLK_DIV=1 instance: card never answers, 16 bytes of 16 clocks each.
    @(negedge clk);
    f_start = 1'b1;
    @(negedge clk);
    f_start = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 1000 && !got; w++) begin
      @(negedge clk);
      if (f_done) got = 1'b1;
    end
    check("fast done_seen", 64'(got), 64'd1);
    repeat (4) @(negedge clk);
    check("fast done_pulses", 64'(f_done_cnt), 64'd1);
    check("fast busy_cycles", 64'(f_busy_cnt), 64'd256);
    check("fast sclk_rises", 64'(f_rise), 64'd128);
    check("fast timeout", 64'(f_timeout), 64'd1);
    check("fast r1", 64'(f_r1), 64'hFF);
    check("fast r32", 64'(f_r32), 64'd0);
    check("fast cs_n", 64'(f_cs_n), 64'd1);
    check("mosi_stable_div1", 64'(f_glitch), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
